// File: rtl/mem_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_hit_arbiter
// Description : Arbitrates a pipeline's instruction-fetch and data ports onto
//               a single word-wide RAM port. Data requests win over fetches.
//               Each granted access is latched and driven to the RAM until
//               ram_ready. A single-cycle hit pulse then returns the loaded
//               word to the requesting side. A saturating watchdog raises a
//               sticky error flag when the RAM stalls for too long.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    : access cycles without ram_ready before ram_err sets
//                (1..65535)
// Ports
//   CLK        in   1   rising-edge clock
//   nRST       in   1   asynchronous active-low reset
//   iREN       in   1   fetch request, held until ihit
//   iaddr      in  32   fetch word address
//   dREN       in   1   data read request, held until dhit
//   dWEN       in   1   data write request, held until dhit
//   daddr      in  32   data word address
//   dstore     in  32   data write word
//   ihit       out  1   fetch-complete pulse
//   dhit       out  1   data-complete pulse
//   iload      out 32   fetched word (valid with ihit, else 0)
//   dload      out 32   read word (valid with dhit after a read, else 0)
//   ram_ren    out  1   RAM read strobe
//   ram_wen    out  1   RAM write strobe
//   ram_addr   out 32   RAM address
//   ram_store  out 32   RAM write data
//   ram_load   in  32   RAM read data, valid with ram_ready
//   ram_ready  in   1   RAM access-complete pulse
//   ram_err    out  1   sticky watchdog-expired flag
// ============================================================================
module mem_hit_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        ram_err
);

  localparam logic [15:0] C_TIMEOUT  = 16'(TIMEOUT);
  localparam logic [15:0] C_WDOG_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;

  // Latched access descriptor, captured at grant.
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic        r_src_d;

  // Registered outputs.
  logic        r_ren;
  logic        r_wen;
  logic        r_ihit;
  logic        r_dhit;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic        r_err;

  // Watchdog.
  logic [15:0] r_wdog;
  logic [15:0] w_wdog_inc;
  logic        w_wdog_expired;

  // Saturating increment; the flag is raised on the edge where the count
  // reaches TIMEOUT so ram_err appears after exactly TIMEOUT stalled cycles.
  assign w_wdog_inc     = (r_wdog == C_WDOG_MAX) ? r_wdog : (r_wdog + 16'd1);
  assign w_wdog_expired = (w_wdog_inc >= C_TIMEOUT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_addr  <= 32'd0;
      r_store <= 32'd0;
      r_wr    <= 1'b0;
      r_src_d <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_ihit  <= 1'b0;
      r_dhit  <= 1'b0;
      r_iload <= 32'd0;
      r_dload <= 32'd0;
      r_err   <= 1'b0;
      r_wdog  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dREN || dWEN) begin
            // A simultaneous read and write request is served as a write.
            r_state <= DACC;
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
            r_src_d <= 1'b1;
            r_ren   <= ~dWEN;
            r_wen   <= dWEN;
            r_wdog  <= 16'd0;
          end else if (iREN) begin
            r_state <= IACC;
            r_addr  <= iaddr;
            r_store <= 32'd0;
            r_wr    <= 1'b0;
            r_src_d <= 1'b0;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_wdog  <= 16'd0;
          end
        end

        IACC, DACC: begin
          // Live request inputs are deliberately not looked at here; the
          // outstanding access runs purely from the latched descriptor.
          if (ram_ready) begin
            r_state <= RESP;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            if (r_src_d) begin
              r_dhit  <= 1'b1;
              r_dload <= r_wr ? 32'd0 : ram_load;
            end else begin
              r_ihit  <= 1'b1;
              r_iload <= ram_load;
            end
          end else begin
            r_wdog <= w_wdog_inc;
            if (w_wdog_expired) begin
              r_err <= 1'b1;
            end
          end
        end

        RESP: begin
          // One-cycle hit; ram_ready seen here is stale and ignored.
          r_state <= IDLE;
          r_ihit  <= 1'b0;
          r_dhit  <= 1'b0;
          r_iload <= 32'd0;
          r_dload <= 32'd0;
        end

        default: begin
          r_state <= IDLE;
          r_ren   <= 1'b0;
          r_wen   <= 1'b0;
          r_ihit  <= 1'b0;
          r_dhit  <= 1'b0;
          r_iload <= 32'd0;
          r_dload <= 32'd0;
        end
      endcase
    end
  end

  assign ihit      = r_ihit;
  assign dhit      = r_dhit;
  assign iload     = r_iload;
  assign dload     = r_dload;
  assign ram_ren   = r_ren;
  assign ram_wen   = r_wen;
  assign ram_addr  = r_addr;
  assign ram_store = r_store;
  assign ram_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_hit_arbiter
// Description : Self-checking bench for mem_hit_arbiter. Directed scenarios
//               followed by randomized request mixes with random RAM latency,
//               checked against a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_hit_arbiter;

  localparam int T_OUT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        ram_err;

  int total = 0;
  int bad   = 0;
  bit exp_err;

  mem_hit_arbiter #(.TIMEOUT(T_OUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ram_load = 0; ram_ready = 0;
  endtask

  task automatic apply_reset();
    nRST = 0;
    clear_inputs();
    tick();
    tick();
    @(negedge CLK);
    nRST = 1;
    exp_err = 0;
    tick();
  endtask

  // Runs one access expected to be granted at the next edge. Starts in IDLE,
  // ends in IDLE. clr_i/clr_d drop the served request during the hit cycle.
  task automatic do_access(input bit src_d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] store, input int delay,
                           input logic [31:0] load, input bit churn,
                           input bit clr_i, input bit clr_d, input string tag);
    logic [33:0] exp_strb;
    logic [33:0] got_strb;
    bit          e;
    // IDLE cycle: nothing driven; a stray ram_ready here must be ignored.
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen} !== 66'd0) begin
      bad++;
      $display("FAIL %s_idle: actual=%h required=0", tag,
               {ihit, dhit, iload, dload, ram_ren, ram_wen});
    end
    total++;
    ram_ready = 1'($urandom_range(0, 1));
    ram_load  = $urandom;
    tick();
    ram_ready = 0;
    for (int k = 0; k < delay; k++) begin
      exp_strb = {src_d ? !wr : 1'b1, src_d ? wr : 1'b0, addr};
      got_strb = {ram_ren, ram_wen, ram_addr};
      if (got_strb !== exp_strb) begin
        bad++;
        $display("FAIL %s_strobe k=%0d: actual=%h required=%h", tag, k, got_strb, exp_strb);
      end
      total++;
      if (src_d) begin
        if (ram_store !== store) begin
          bad++;
          $display("FAIL %s_store k=%0d: actual=%h required=%h", tag, k, ram_store, store);
        end
        total++;
      end
      if ({ihit, dhit, iload, dload} !== 66'd0) begin
        bad++;
        $display("FAIL %s_early_hit k=%0d: actual=%h required=0", tag, k,
                 {ihit, dhit, iload, dload});
      end
      total++;
      e = exp_err || (k >= T_OUT);
      if (ram_err !== e) begin
        bad++;
        $display("FAIL %s_err k=%0d: actual=%b required=%b", tag, k, ram_err, e);
      end
      total++;
      if (churn) begin
        iaddr  = iaddr + 32'h200;
        daddr  = $urandom;
        dstore = $urandom;
      end
      if (k == delay - 1) begin
        ram_ready = 1;
        ram_load  = load;
      end
      tick();
      ram_ready = 0;
      ram_load  = $urandom;
    end
    if (delay - 1 >= T_OUT) exp_err = 1;
    // Hit cycle.
    if ({ihit, dhit} !== {!src_d, src_d}) begin
      bad++;
      $display("FAIL %s_hit: actual=%b%b required=%b%b", tag, ihit, dhit, !src_d, src_d);
    end
    total++;
    if (iload !== (src_d ? 32'd0 : load)) begin
      bad++;
      $display("FAIL %s_iload: actual=%h required=%h", tag, iload, src_d ? 32'd0 : load);
    end
    total++;
    if (dload !== ((src_d && !wr) ? load : 32'd0)) begin
      bad++;
      $display("FAIL %s_dload: actual=%h required=%h", tag, dload,
               (src_d && !wr) ? load : 32'd0);
    end
    total++;
    if ({ram_ren, ram_wen, ram_err} !== {2'b00, exp_err}) begin
      bad++;
      $display("FAIL %s_resp_strb: actual=%b required=%b", tag,
               {ram_ren, ram_wen, ram_err}, {2'b00, exp_err});
    end
    total++;
    if (clr_i) iREN = 0;
    if (clr_d) begin dREN = 0; dWEN = 0; end
    ram_ready = 1'($urandom_range(0, 1));
    ram_load  = $urandom;
    tick();
    ram_ready = 0;
    // Back in IDLE: the pulse lasted exactly one cycle.
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen} !== 66'd0) begin
      bad++;
      $display("FAIL %s_after: actual=%h required=0", tag,
               {ihit, dhit, iload, dload, ram_ren, ram_wen});
    end
    total++;
  endtask

  task automatic test_reset();
    nRST = 0;
    clear_inputs();
    #12;
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, ram_err} !== 131'd0) begin
      bad++;
      $display("FAIL reset_outputs: actual=%h required=0",
               {ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, ram_err});
    end
    total++;
    // Reset dominates active requests and ram_ready across a clock edge.
    iREN = 1; dWEN = 1; daddr = 32'hFFFF_0000; dstore = 32'hA5A5_A5A5;
    ram_ready = 1; ram_load = 32'h1234_5678;
    tick();
    if ({ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, ram_err} !== 131'd0) begin
      bad++;
      $display("FAIL reset_held: actual=%h required=0",
               {ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, ram_err});
    end
    total++;
    apply_reset();
  endtask

  task automatic test_fetch();
    apply_reset();
    iREN = 1; iaddr = 32'h100;
    do_access(0, 0, 32'h100, 32'd0, 1, 32'hDEADBEEF, 0, 1, 0, "fetch");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    iREN = 1; iaddr = 32'h180;
    dREN = 1; daddr = 32'h200; dstore = 32'h0;
    do_access(1, 0, 32'h200, 32'h0, 2, 32'hCAFE_0001, 0, 0, 1, "simul_d");
    do_access(0, 0, 32'h180, 32'h0, 1, 32'hCAFE_0002, 0, 1, 0, "simul_i");
  endtask

  task automatic test_write();
    apply_reset();
    dWEN = 1; daddr = 32'h40; dstore = 32'h12345678;
    do_access(1, 1, 32'h40, 32'h12345678, 5, 32'hBAD0_BAD0, 0, 0, 1, "write");
    // Read and write together resolve to a write.
    dREN = 1; dWEN = 1; daddr = 32'h44; dstore = 32'h0BAD_F00D;
    do_access(1, 1, 32'h44, 32'h0BAD_F00D, 1, 32'h7777_7777, 0, 0, 1, "rw_both");
  endtask

  task automatic test_watchdog();
    apply_reset();
    iREN = 1; iaddr = 32'h500;
    do_access(0, 0, 32'h500, 32'h0, 9, 32'h5555_AAAA, 0, 1, 0, "wdog");
    iREN = 1; iaddr = 32'h504;
    do_access(0, 0, 32'h504, 32'h0, 1, 32'h0000_0001, 0, 1, 0, "wdog_sticky");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dREN = 1; daddr = 32'h900;
    tick();
    if ({ram_ren, ram_wen, ram_addr} !== {2'b10, 32'h900}) begin
      bad++;
      $display("FAIL rstmid_grant: actual=%h required=%h", {ram_ren, ram_wen, ram_addr},
               {2'b10, 32'h900});
    end
    total++;
    #2 nRST = 0;
    #1;
    if ({ram_ren, ram_wen, ihit, dhit} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_drop: actual=%b required=0000", {ram_ren, ram_wen, ihit, dhit});
    end
    total++;
    ram_ready = 1; ram_load = 32'hFEED;
    tick();
    ram_ready = 0;
    if ({ihit, dhit, dload} !== 34'd0) begin
      bad++;
      $display("FAIL rstmid_nohit: actual=%h required=0", {ihit, dhit, dload});
    end
    total++;
    @(negedge CLK);
    nRST = 1;
    exp_err = 0;
    do_access(1, 0, 32'h900, 32'h0, 2, 32'h0F0F_0F0F, 0, 0, 1, "rstmid_regrant");
  endtask

  task automatic test_churn();
    apply_reset();
    iREN = 1; iaddr = 32'h100;
    do_access(0, 0, 32'h100, 32'h0, 3, 32'h3333_3333, 1, 1, 0, "churn");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    iREN = 1; iaddr = 32'h600;
    do_access(0, 0, 32'h600, 32'h0, 1, 32'h6000_0001, 0, 0, 0, "b2b_1");
    do_access(0, 0, 32'h600, 32'h0, 1, 32'h6000_0002, 0, 1, 0, "b2b_2");
  endtask

  task automatic test_random();
    bit ir, dr, dw;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!ir && !dr && !dw) ir = 1;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
      iREN = ir; dREN = dr; dWEN = dw;
      if (dr || dw) begin
        do_access(1, dw, daddr, dstore, $urandom_range(1, 6), $urandom,
                  1, 0, 1, "rnd_d");
        if (ir)
          do_access(0, 0, iaddr, 32'h0, $urandom_range(1, 6), $urandom,
                    1, 1, 0, "rnd_di");
      end else begin
        do_access(0, 0, iaddr, 32'h0, $urandom_range(1, 6), $urandom,
                  1, 1, 0, "rnd_i");
      end
    end
  endtask

  initial begin
    exp_err = 0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_watchdog();
    test_reset_mid();
    test_churn();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
